// File: rtl/lvds_rx_align_ctrl.sv
// PLL reset sequencing, lock qualification and bitslip word-alignment training
// for the LVDS receive path. Runs entirely on the free-running reference clock.
module lvds_rx_align_ctrl #(
    parameter int unsigned       WORD_W             = 6,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN      = 6'b111000,
    parameter int unsigned       RST_CYCLES         = 16,
    parameter int unsigned       LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned       MATCH_COUNT        = 64,
    parameter int unsigned       SLIP_SETTLE        = 8,
    parameter int unsigned       CNT_W              = 11
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              train_en,
    input  logic              realign,
    input  logic [WORD_W-1:0] rx_word,
    input  logic              rx_valid,
    output logic              pll_rst,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_err,
    output logic [2:0]        slip_count,
    output logic [2:0]        state_dbg
);

    localparam int unsigned SLIP_W = 3;

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_DONE   = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  MATCH_LAST  = CNT_W'(MATCH_COUNT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SLIP_SETTLE - 1);
    localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_CHECK     = 3'd2,
        ST_SLIP      = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_ALIGNED   = 3'd5,
        ST_FAIL      = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [CNT_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [SLIP_W-1:0] slip_q, slip_d;
    logic              pll_rst_q, pll_rst_d;
    logic              bitslip_q, bitslip_d;
    logic              aligned_q, aligned_d;
    logic              align_err_q, align_err_d;
    logic              lk;

    assign lk = sync_q[1];

    // tmr is shared: reset hold length in RESET_PLL, lock stability in
    // WAIT_LOCK, post-slip blanking in SETTLE.
    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        tmr_d   = tmr_q;
        match_d = match_q;
        slip_d  = slip_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (!lk) begin
                    tmr_d = '0;
                end else if (tmr_q != LOCK_DONE) begin
                    tmr_d = tmr_q + CNT_W'(1);
                end else if (train_en) begin
                    state_d = ST_CHECK;
                    tmr_d   = '0;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_word == TRAIN_PATTERN) begin
                        match_d = match_q + CNT_W'(1);
                        if (match_q == MATCH_LAST) begin
                            state_d = ST_ALIGNED;
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q == SLIP_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_SLIP;
                            slip_d  = slip_q + SLIP_W'(1);
                        end
                    end
                end
            end
            ST_SLIP: begin
                state_d = ST_SETTLE;
                tmr_d   = '0;
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + CNT_W'(1);
                end
            end
            ST_ALIGNED, ST_FAIL: begin
                if (realign) begin
                    state_d = ST_CHECK;
                    slip_d  = '0;
                    match_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                tmr_d   = '0;
            end
        endcase

        // Lock loss once training has begun overrides every other transition.
        if (!lk && (state_q inside {ST_CHECK, ST_SLIP, ST_SETTLE, ST_ALIGNED, ST_FAIL})) begin
            state_d = ST_RESET_PLL;
            tmr_d   = '0;
        end

        if (state_d == ST_RESET_PLL) begin
            slip_d  = '0;
            match_d = '0;
        end

        pll_rst_d   = (state_d == ST_RESET_PLL);
        bitslip_d   = (state_d == ST_SLIP);
        aligned_d   = (state_d == ST_ALIGNED);
        align_err_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET_PLL;
            sync_q      <= '0;
            tmr_q       <= '0;
            match_q     <= '0;
            slip_q      <= '0;
            pll_rst_q   <= 1'b1;
            bitslip_q   <= 1'b0;
            aligned_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tmr_q       <= tmr_d;
            match_q     <= match_d;
            slip_q      <= slip_d;
            pll_rst_q   <= pll_rst_d;
            bitslip_q   <= bitslip_d;
            aligned_q   <= aligned_d;
            align_err_q <= align_err_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_err  = align_err_q;
    assign slip_count = slip_q;
    assign state_dbg  = state_q;

    a_bitslip_single: assert property (@(posedge refclk) disable iff (rst)
        bitslip |=> !bitslip);
    a_slip_bound: assert property (@(posedge refclk) disable iff (rst)
        slip_count <= SLIP_MAX);

endmodule
